noc_async_fifo_rd: RTL and testbench

NOC_ASYNC_FIFO_RD -- requirements
Module: noc_async_fifo_rd

---
 rtl/noc_async_fifo_rd.sv | 120 ++++++++++++
 tb/tb_noc_async_fifo_rd.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_async_fifo_rd.sv
// Read side of a Gray-pointer asynchronous FIFO feeding a NoC router port.
// Latency: 3 clk_noc_i edges from a remote write-pointer change to pkt_valid_o (2 sync + 1 fetch).
// Backpressure: valid/ready output slot; pkt_o holds while stalled, refetch on the accept cycle.
module noc_async_fifo_rd #(
    parameter int NOC_ASYNC_FIFO_PACKET_SIZE = 64,
    parameter int NOC_ASYNC_FIFO_AWIDTH      = 3
) (
    input  logic                                  clk_noc_i,
    input  logic                                  reset_noc_n_i,
    input  logic [NOC_ASYNC_FIFO_PACKET_SIZE-1:0] noc_fifo_pm_out_data_i,
    input  logic [NOC_ASYNC_FIFO_AWIDTH:0]        noc_fifo_pm_out_waddr_i,
    output logic [NOC_ASYNC_FIFO_AWIDTH:0]        noc_fifo_pm_out_raddr_o,
    output logic [NOC_ASYNC_FIFO_PACKET_SIZE-1:0] pkt_o,
    output logic                                  pkt_valid_o,
    input  logic                                  pkt_ready_i,
    output logic [NOC_ASYNC_FIFO_AWIDTH:0]        fill_o,
    output logic                                  err_o
);

    localparam int P = NOC_ASYNC_FIFO_PACKET_SIZE;
    localparam int A = NOC_ASYNC_FIFO_AWIDTH;

    // Pointer constants: one step, and the FIFO depth expressed in pointer width.
    localparam logic [A:0] PTR_ONE   = {{A{1'b0}}, 1'b1};
    localparam logic [A:0] DEPTH_PTR = {1'b1, {A{1'b0}}};

    // Gray to binary by prefix XOR starting at the MSB.
    function automatic logic [A:0] gray2bin(input logic [A:0] g);
        logic [A:0] b;
        b[A] = g[A];
        for (int i = A - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // State registers.
    logic [A:0]   wsync1_q, wsync1_d;
    logic [A:0]   wsync2_q, wsync2_d;
    logic [A:0]   rptr_q,   rptr_d;
    logic [A:0]   raddr_q,  raddr_d;
    logic [P-1:0] pkt_q,    pkt_d;
    logic         pkt_valid_q, pkt_valid_d;
    logic [A:0]   fill_q,   fill_d;
    logic         err_q,    err_d;

    // Combinational helpers.
    logic         empty;
    logic         fetch;
    logic [A:0]   wbin_next;
    logic [A:0]   diff_next;

    // Two-stage synchroniser for the remote Gray write pointer; plain copies, nothing in between.
    always_comb begin
        wsync1_d = noc_fifo_pm_out_waddr_i;
        wsync2_d = wsync1_q;
    end

    // Empty compares full Gray pointers, so the MSB separates "empty" from "full after wrap".
    always_comb begin
        empty = (wsync2_q == raddr_q);
        fetch = !empty && (!pkt_valid_q || pkt_ready_i);
    end

    // Output slot: load on fetch, drop valid on a bare accept, otherwise hold.
    always_comb begin
        rptr_d      = rptr_q;
        raddr_d     = raddr_q;
        pkt_d       = pkt_q;
        pkt_valid_d = pkt_valid_q;
        if (fetch) begin
            rptr_d      = rptr_q + PTR_ONE;
            raddr_d     = rptr_d ^ (rptr_d >> 1);
            pkt_d       = noc_fifo_pm_out_data_i;
            pkt_valid_d = 1'b1;
        end else if (pkt_valid_q && pkt_ready_i) begin
            pkt_valid_d = 1'b0;
        end
    end

    // Occupancy is computed from next-state values so the registered fill_o matches the
    // pointers visible in the same cycle; a difference beyond depth means a corrupted pointer.
    always_comb begin
        wbin_next = gray2bin(wsync2_d);
        diff_next = wbin_next - rptr_d;
        fill_d    = diff_next;
        err_d     = err_q || (diff_next > DEPTH_PTR);
    end

    // All state resets asynchronously; leaving reset only takes effect at a clock edge.
    always_ff @(posedge clk_noc_i or negedge reset_noc_n_i) begin
        if (!reset_noc_n_i) begin
            wsync1_q    <= '0;
            wsync2_q    <= '0;
            rptr_q      <= '0;
            raddr_q     <= '0;
            pkt_q       <= '0;
            pkt_valid_q <= 1'b0;
            fill_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            wsync1_q    <= wsync1_d;
            wsync2_q    <= wsync2_d;
            rptr_q      <= rptr_d;
            raddr_q     <= raddr_d;
            pkt_q       <= pkt_d;
            pkt_valid_q <= pkt_valid_d;
            fill_q      <= fill_d;
            err_q       <= err_d;
        end
    end

    // Port drive straight from registers.
    assign noc_fifo_pm_out_raddr_o = raddr_q;
    assign pkt_o                   = pkt_q;
    assign pkt_valid_o             = pkt_valid_q;
    assign fill_o                  = fill_q;
    assign err_o                   = err_q;

endmodule

// File: tb/tb_noc_async_fifo_rd.sv
module tb_noc_async_fifo_rd;

    localparam int P = 8;
    localparam int A = 2;

    logic         clk;
    logic         rst_n;
    logic [P-1:0] data_i;
    logic [A:0]   waddr_i;
    logic [A:0]   raddr_o;
    logic [P-1:0] pkt_o;
    logic         pkt_valid_o;
    logic         pkt_ready_i;
    logic [A:0]   fill_o;
    logic         err_o;

    noc_async_fifo_rd #(
        .NOC_ASYNC_FIFO_PACKET_SIZE(P),
        .NOC_ASYNC_FIFO_AWIDTH(A)
    ) dut (
        .clk_noc_i(clk),
        .reset_noc_n_i(rst_n),
        .noc_fifo_pm_out_data_i(data_i),
        .noc_fifo_pm_out_waddr_i(waddr_i),
        .noc_fifo_pm_out_raddr_o(raddr_o),
        .pkt_o(pkt_o),
        .pkt_valid_o(pkt_valid_o),
        .pkt_ready_i(pkt_ready_i),
        .fill_o(fill_o),
        .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Remote writer model: storage, binary write pointer, expected-packet queue.
    logic [P-1:0] mem [4];
    logic [A:0]   wptr;
    logic [A:0]   rd_bin;
    logic [P-1:0] sb_q [$];

    function automatic logic [A:0] bin2gray(input logic [A:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [A:0] gray2bin(input logic [A:0] g);
        logic [A:0] b;
        b[A] = g[A];
        for (int i = A - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    assign rd_bin = gray2bin(raddr_o);
    assign data_i = mem[rd_bin[1:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wr(input logic [P-1:0] d);
        mem[wptr[1:0]] = d;
        wptr           = wptr + 3'd1;
        waddr_i        = bin2gray(wptr);
        sb_q.push_back(d);
    endtask

    function automatic logic has_space();
        logic [A:0] used;
        used = wptr - rd_bin;
        return used < 3'd4;
    endfunction

    task automatic do_reset();
        rst_n       = 1'b0;
        pkt_ready_i = 1'b0;
        wptr        = '0;
        waddr_i     = '0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Pop and compare one accepted packet.
    task automatic sb_pop(input string name);
        logic [P-1:0] exp;
        if (sb_q.size() == 0) begin
            check({name, "_underflow"}, 32'd1, 32'd0);
        end else begin
            exp = sb_q.pop_front();
            check(name, pkt_o, exp);
        end
    endtask

    typedef struct {
        logic         wr_en;
        logic [P-1:0] wr_dat;
        logic         rdy;
        logic         exp_vld;
        logic [P-1:0] exp_pkt;
        logic [A:0]   exp_fill;
        logic [A:0]   exp_raddr;
    } vec_t;

    vec_t vt [11];

    initial begin
        int           rcv;
        int           wcnt;
        int           guard;
        logic [A:0]   prev_rd;
        logic         saw_wrap;
        logic         prev_v, prev_r;
        logic [P-1:0] prev_pkt;

        // Four writes with the output stalled, then drain at full rate.
        vt[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0};
        vt[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0};
        vt[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 3'd1, 3'd0};
        vt[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 8'h11, 3'd1, 3'd1};
        vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 3'd2, 3'd1};
        vt[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 3'd3, 3'd1};
        vt[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 3'd3, 3'd1};
        vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 3'd2, 3'd3};
        vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 3'd1, 3'd2};
        vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 3'd0, 3'd6};
        vt[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h44, 3'd0, 3'd6};

        rst_n       = 1'b0;
        pkt_ready_i = 1'b0;
        wptr        = '0;
        waddr_i     = '0;
        for (int i = 0; i < 4; i++) mem[i] = '0;

        // Reset state.
        do_reset();
        check("rst_valid", pkt_valid_o, 1'b0);
        check("rst_pkt",   pkt_o, 8'h00);
        check("rst_fill",  fill_o, 3'd0);
        check("rst_raddr", raddr_o, 3'd0);
        check("rst_err",   err_o, 1'b0);

        // Table-driven cycle sequence.
        for (int i = 0; i < 11; i++) begin
            pkt_ready_i = vt[i].rdy;
            if (vt[i].wr_en) wr(vt[i].wr_dat);
            #1;
            check($sformatf("vec%0d_valid", i), pkt_valid_o, vt[i].exp_vld);
            check($sformatf("vec%0d_pkt", i),   pkt_o,       vt[i].exp_pkt);
            check($sformatf("vec%0d_fill", i),  fill_o,      vt[i].exp_fill);
            check($sformatf("vec%0d_raddr", i), raddr_o,     vt[i].exp_raddr);
            @(posedge clk);
            #1;
        end

        // Random-ready streaming of 20 packets with pointer wrap.
        do_reset();
        rcv = 0; wcnt = 0; saw_wrap = 1'b0; prev_rd = rd_bin;
        for (int cyc = 0; cyc < 600 && rcv < 20; cyc++) begin
            pkt_ready_i = 1'($urandom_range(0, 1));
            if (wcnt < 20 && has_space() && $urandom_range(0, 1) == 1) begin
                wr(8'(8'h30 + wcnt));
                wcnt++;
            end
            #1;
            if (pkt_valid_o && pkt_ready_i) begin
                sb_pop("stream_data");
                rcv++;
            end
            @(posedge clk);
            #1;
            if (prev_rd == 3'd7 && rd_bin == 3'd0) saw_wrap = 1'b1;
            prev_rd = rd_bin;
        end
        check("stream_count", rcv, 20);
        check("stream_sb_empty", sb_q.size(), 0);
        check("stream_wrap", saw_wrap, 1'b1);
        check("stream_raddr_end", raddr_o, bin2gray(3'd4));

        // Ready toggling every cycle with continuous writes.
        do_reset();
        prev_v = 1'b0; prev_r = 1'b0; prev_pkt = '0; wcnt = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            pkt_ready_i = 1'(cyc % 2);
            if (has_space()) begin
                wr(8'(8'h80 + wcnt));
                wcnt++;
            end
            #1;
            if (prev_v && !prev_r) begin
                check("stall_pkt",   pkt_o, prev_pkt);
                check("stall_valid", pkt_valid_o, 1'b1);
            end
            if (cyc >= 8 && pkt_ready_i) check("toggle_thru", pkt_valid_o, 1'b1);
            if (pkt_valid_o && pkt_ready_i) sb_pop("toggle_data");
            prev_v = pkt_valid_o; prev_r = pkt_ready_i; prev_pkt = pkt_o;
            @(posedge clk);
            #1;
        end
        pkt_ready_i = 1'b1;
        guard = 0;
        while ((sb_q.size() != 0) && guard < 40) begin
            #1;
            if (pkt_valid_o && pkt_ready_i) sb_pop("drain_data");
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_sb_empty", sb_q.size(), 0);

        // Write pointer far ahead of the read pointer: sticky error.
        do_reset();
        wptr    = 3'd6;
        waddr_i = bin2gray(3'd6);
        #1;
        check("err_before_sync", err_o, 1'b0);
        @(posedge clk);
        #1;
        check("err_one_stage", err_o, 1'b0);
        guard = 0;
        while (!err_o && guard < 4) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("err_set", err_o, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("err_fetch_continues", pkt_valid_o, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("err_sticky", err_o, 1'b1);
        do_reset();
        check("err_cleared", err_o, 1'b0);

        // Reset asserted mid-transfer clears outputs before the next edge.
        for (int i = 0; i < 3; i++) begin
            wr(8'(8'h50 + i));
            @(posedge clk);
            #1;
        end
        guard = 0;
        while (!(pkt_valid_o && fill_o == 3'd2) && guard < 10) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("mid_reach_valid", pkt_valid_o, 1'b1);
        check("mid_reach_fill",  fill_o, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", pkt_valid_o, 1'b0);
        check("async_pkt",   pkt_o, 8'h00);
        check("async_fill",  fill_o, 3'd0);
        check("async_raddr", raddr_o, 3'd0);
        check("async_err",   err_o, 1'b0);
        wptr = '0; waddr_i = '0; sb_q.delete();
        for (int i = 0; i < 4; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("release_raddr", raddr_o, 3'd0);
        @(posedge clk);
        #1;
        pkt_ready_i = 1'b1;
        wr(8'hC3);
        guard = 0;
        while (!pkt_valid_o && guard < 8) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("post_reset_valid", pkt_valid_o, 1'b1);
        if (pkt_valid_o) sb_pop("post_reset_entry0");
        check("post_reset_raddr", raddr_o, 3'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
